serial_subtractor: RTL

- Bit-serial two's-complement subtractor: diff = a - b - bin, computed LSB-first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop.
- Low-area counterpart to the ripple adder chain in the ALU datapath, for multi-cycle SUB/CMP ops.
- Sits beside the adder; the ALU control FSM drives it with a start/done handshake.

---
 rtl/alu_pkg.sv | 12 +
 rtl/full_subtractor1.sv | 22 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control state encoding for the serial subtractor and default width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/full_subtractor1.sv
// One-bit full subtractor (diff = a - b - bin), built as two cascaded half-subtractors plus an OR.
module full_subtractor1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic hs1_diff;
   logic hs1_bout;
   logic hs2_bout;

   assign hs1_diff = a ^ b;
   assign hs1_bout = ~a & b;

   assign diff     = hs1_diff ^ bin;
   assign hs2_bout = ~hs1_diff & bin;

   assign bout     = hs1_bout | hs2_bout;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock: diff = a - b - bin (mod 2^WIDTH).
// Define SERIAL_SUB_BIN_EN to add the borrow-in port bin for multi-word chaining.
module serial_subtractor
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero
);

   if (WIDTH < 2) begin : g_width_check
      $error("serial_subtractor: WIDTH must be >= 2");
   end

   localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

   sub_state_t       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             bor_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       msb_q;   // {a[MSB], b[MSB]} captured at start
   logic             busy_q;
   logic             done_q;
   logic             borrow_q;
   logic             overflow_q;
   logic             zero_q;

   logic             bin_in;
   logic             cell_diff;
   logic             cell_bout;
   logic [WIDTH-1:0] diff_next;
   logic             accept;

`ifdef SERIAL_SUB_BIN_EN
   assign bin_in = bin;
`else
   assign bin_in = 1'b0;
`endif

   full_subtractor1 u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (bor_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   assign diff_next = {cell_diff, diff_q[WIDTH-1:1]};
   assign accept    = start && (state_q != RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         bor_q      <= 1'b0;
         cnt_q      <= '0;
         msb_q      <= 2'b00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == RUN) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            diff_q <= diff_next;
            bor_q  <= cell_bout;
            if (cnt_q == LastBit) begin
               state_q    <= DONE;
               cnt_q      <= '0;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               borrow_q   <= cell_bout;
               overflow_q <= (msb_q[1] != msb_q[0]) && (diff_next[WIDTH-1] != msb_q[1]);
               zero_q     <= (diff_next == '0);
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (accept) begin
            // Start is honoured from IDLE and from DONE alike, so ops can run back to back.
            state_q    <= RUN;
            a_q        <= a;
            b_q        <= b;
            msb_q      <= {a[WIDTH-1], b[WIDTH-1]};
            bor_q      <= bin_in;
            cnt_q      <= '0;
            diff_q     <= '0;
            busy_q     <= 1'b1;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
         end else begin
            state_q <= IDLE;
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule
